// File: rtl/seg7_seq_checker.sv
// Display-bus monitor: decodes 7-segment patterns back to digits and checks
// that they follow a mod-8 up-count, with a HUNT/SYNC/LOCKED lock tracker.
module seg7_seq_checker #(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [6:0]       SEG_IN,
    input  logic             SEG_VALID,
    input  logic             ERR_CLR,
    output logic [2:0]       DIGIT,
    output logic             DIGIT_VALID,
    output logic             CODE_ERR,
    output logic             SEQ_ERR,
    output logic             LOCKED,
    output logic [ERR_W-1:0] ERR_CNT
);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] prev;
    logic [3:0] match;
    logic [3:0] miss;

    logic       legal;
    logic       blank;
    logic [2:0] dec;
    logic [2:0] expected;
    logic       code_ev;
    logic       seq_ev;

    always_comb begin
        legal = 1'b1;
        blank = 1'b0;
        dec   = 3'd0;
        case (SEG_IN)
            7'b1111110: dec = 3'd0;
            7'b0110000: dec = 3'd1;
            7'b1101101: dec = 3'd2;
            7'b1111001: dec = 3'd3;
            7'b0110011: dec = 3'd4;
            7'b1011011: dec = 3'd5;
            7'b1011111: dec = 3'd6;
            7'b1110000: dec = 3'd7;
            7'b0000000: begin legal = 1'b0; blank = 1'b1; end
            default:    legal = 1'b0;
        endcase
    end

    // 3-bit arithmetic gives the 7 -> 0 wrap for free
    assign expected = prev + 3'd1;
    assign code_ev  = SEG_VALID && !legal && !blank;
    assign seq_ev   = SEG_VALID && legal && (state == ST_LOCKED) && (dec != expected);

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state       <= ST_HUNT;
            prev        <= 3'd0;
            match       <= 4'd0;
            miss        <= 4'd0;
            DIGIT       <= 3'd0;
            DIGIT_VALID <= 1'b0;
            CODE_ERR    <= 1'b0;
            SEQ_ERR     <= 1'b0;
            LOCKED      <= 1'b0;
            ERR_CNT     <= '0;
        end else begin
            DIGIT_VALID <= 1'b0;
            CODE_ERR    <= code_ev;
            SEQ_ERR     <= seq_ev;

            // Clear beats a same-cycle error event
            if (ERR_CLR)
                ERR_CNT <= '0;
            else if ((code_ev || seq_ev) && (ERR_CNT != {ERR_W{1'b1}}))
                ERR_CNT <= ERR_CNT + 1'b1;

            if (SEG_VALID) begin
                if (legal) begin
                    DIGIT       <= dec;
                    DIGIT_VALID <= 1'b1;
                    prev        <= dec;
                end

                case (state)
                    ST_HUNT: begin
                        if (legal) begin
                            state <= ST_SYNC;
                            match <= 4'd0;
                        end
                    end
                    ST_SYNC: begin
                        if (!legal) begin
                            state <= ST_HUNT;
                        end else if (dec == expected) begin
                            if (match + 4'd1 == 4'(LOCK_CNT)) begin
                                state  <= ST_LOCKED;
                                LOCKED <= 1'b1;
                                miss   <= 4'd0;
                            end else begin
                                match <= match + 4'd1;
                            end
                        end else begin
                            match <= 4'd0;
                        end
                    end
                    ST_LOCKED: begin
                        // A blank bus means the display was reset: drop lock quietly
                        if (blank) begin
                            state  <= ST_HUNT;
                            LOCKED <= 1'b0;
                        end else if (legal && dec == expected) begin
                            miss <= 4'd0;
                        end else if (miss + 4'd1 == 4'(LOSS_CNT)) begin
                            state  <= ST_HUNT;
                            LOCKED <= 1'b0;
                        end else begin
                            miss <= miss + 4'd1;
                        end
                    end
                    default: begin
                        state  <= ST_HUNT;
                        LOCKED <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_seq_checker.sv
// Self-checking bench for seg7_seq_checker: directed scenarios plus random
// traffic compared against a digit-level reference model.
module tb_seg7_seq_checker;

    localparam int LOCK_CNT = 3;
    localparam int LOSS_CNT = 2;
    localparam int ERR_W    = 8;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic             CLK = 1'b0;
    logic             RESETN = 1'b0;
    logic [6:0]       SEG_IN = 7'd0;
    logic             SEG_VALID = 1'b0;
    logic             ERR_CLR = 1'b0;
    logic [2:0]       DIGIT;
    logic             DIGIT_VALID;
    logic             CODE_ERR;
    logic             SEQ_ERR;
    logic             LOCKED;
    logic [ERR_W-1:0] ERR_CNT;

    seg7_seq_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERR_W(ERR_W)) dut (
        .CLK(CLK), .RESETN(RESETN), .SEG_IN(SEG_IN), .SEG_VALID(SEG_VALID),
        .ERR_CLR(ERR_CLR), .DIGIT(DIGIT), .DIGIT_VALID(DIGIT_VALID),
        .CODE_ERR(CODE_ERR), .SEQ_ERR(SEQ_ERR), .LOCKED(LOCKED), .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int passCount  = 0;
    int totalCount = 0;
    int failCount  = 0;

    logic [6:0] segTable [8] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000};
    localparam logic [6:0] SEG_BLANK   = 7'b0000000;
    localparam logic [6:0] SEG_ILLEGAL = 7'b1111111;

    // Reference model kept at the level of digits and plain integers
    typedef enum {M_HUNT, M_SYNC, M_LOCKED} mstate_t;
    mstate_t mState;
    int mPrev, mMatch, mMiss;
    int eDigit, eDv, eCe, eSe, eErr;

    // Returns 0..7 for a digit, -1 for blank, -2 for anything else
    function automatic int decodeSeg(input logic [6:0] s);
        if (s == SEG_BLANK) return -1;
        for (int i = 0; i < 8; i++)
            if (segTable[i] == s) return i;
        return -2;
    endfunction

    task automatic modelStep(input logic rstn, input logic [6:0] seg,
                             input logic valid, input logic clr);
        int d, expd;
        if (!rstn) begin
            mState = M_HUNT; mPrev = 0; mMatch = 0; mMiss = 0;
            eDigit = 0; eDv = 0; eCe = 0; eSe = 0; eErr = 0;
            return;
        end
        eDv = 0; eCe = 0; eSe = 0;
        if (valid) begin
            d    = decodeSeg(seg);
            expd = (mPrev + 1) % 8;
            if (d >= 0) begin
                eDigit = d;
                eDv    = 1;
            end
            if (d == -2) eCe = 1;
            if (mState == M_HUNT) begin
                if (d >= 0) begin mState = M_SYNC; mMatch = 0; end
            end else if (mState == M_SYNC) begin
                if (d < 0) mState = M_HUNT;
                else if (d == expd) begin
                    mMatch++;
                    if (mMatch == LOCK_CNT) begin mState = M_LOCKED; mMiss = 0; end
                end else mMatch = 0;
            end else begin
                if (d == -1) mState = M_HUNT;
                else if (d == expd) mMiss = 0;
                else begin
                    if (d >= 0) eSe = 1;
                    mMiss++;
                    if (mMiss == LOSS_CNT) mState = M_HUNT;
                end
            end
            if (d >= 0) mPrev = d;
        end
        if (clr) eErr = 0;
        else if ((eCe || eSe) && eErr < ERR_MAX) eErr++;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".DIGIT"},       32'(DIGIT),       32'(eDigit));
        checkVal({tag, ".DIGIT_VALID"}, 32'(DIGIT_VALID), 32'(eDv));
        checkVal({tag, ".CODE_ERR"},    32'(CODE_ERR),    32'(eCe));
        checkVal({tag, ".SEQ_ERR"},     32'(SEQ_ERR),     32'(eSe));
        checkVal({tag, ".LOCKED"},      32'(LOCKED),      32'(mState == M_LOCKED));
        checkVal({tag, ".ERR_CNT"},     32'(ERR_CNT),     32'(eErr));
    endtask

    // Drive one sample between edges, update the model at the edge, check just after
    task automatic applyStimulus(input logic rstn, input logic [6:0] seg, input logic valid,
                                 input logic clr, input string tag);
        @(negedge CLK);
        RESETN = rstn; SEG_IN = seg; SEG_VALID = valid; ERR_CLR = clr;
        @(posedge CLK);
        modelStep(rstn, seg, valid, clr);
        #1;
        checkOutput(tag);
    endtask

    task automatic feedDigit(input int d, input string tag);
        applyStimulus(1'b1, segTable[d], 1'b1, 1'b0, tag);
    endtask

    initial begin
        int r, d;
        logic [6:0] seg;
        logic valid, clr;

        // Reset held while legal codes stream in
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, segTable[i], 1'b1, 1'b0, "reset");
        checkVal("reset.LOCKED_const", 32'(LOCKED), 32'd0);

        for (int i = 0; i < 4; i++) feedDigit(i, "lock");
        checkVal("lock.DIGIT_const", 32'(DIGIT), 32'd3);
        checkVal("lock.LOCKED_const", 32'(LOCKED), 32'd1);

        for (int i = 4; i < 10; i++) feedDigit(i % 8, "wrap");
        checkVal("wrap.DIGIT_const", 32'(DIGIT), 32'd1);
        checkVal("wrap.LOCKED_const", 32'(LOCKED), 32'd1);

        feedDigit(2, "seq");
        feedDigit(5, "seq");
        checkVal("seq.SEQ_ERR_const", 32'(SEQ_ERR), 32'd1);
        feedDigit(6, "seq");
        feedDigit(1, "seq");
        feedDigit(4, "seq");
        checkVal("seq.ERR_CNT_const", 32'(ERR_CNT), 32'd3);
        checkVal("seq.LOCKED_const", 32'(LOCKED), 32'd0);

        for (int i = 0; i < 4; i++) feedDigit(i, "relock");
        applyStimulus(1'b1, SEG_ILLEGAL, 1'b1, 1'b0, "illegal");
        checkVal("illegal.DIGIT_const", 32'(DIGIT), 32'd3);
        checkVal("illegal.CODE_ERR_const", 32'(CODE_ERR), 32'd1);
        feedDigit(4, "illegal");
        checkVal("illegal.SEQ_ERR_const", 32'(SEQ_ERR), 32'd0);

        applyStimulus(1'b1, SEG_BLANK, 1'b1, 1'b0, "blank");
        checkVal("blank.LOCKED_const", 32'(LOCKED), 32'd0);
        checkVal("blank.ERR_CNT_const", 32'(ERR_CNT), 32'd4);
        for (int i = 0; i < 4; i++) feedDigit(i, "relock2");
        applyStimulus(1'b1, segTable[6], 1'b1, 1'b1, "clr");
        checkVal("clr.ERR_CNT_const", 32'(ERR_CNT), 32'd0);

        for (int i = 0; i < 260; i++) applyStimulus(1'b1, SEG_ILLEGAL, 1'b1, 1'b0, "sat");
        checkVal("sat.ERR_CNT_const", 32'(ERR_CNT), 32'd255);

        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 7'($urandom), 1'b0, 1'b0, "gate");

        // Random traffic biased toward the correct next digit
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            valid = 1'b1;
            if (r < 12) seg = segTable[(mPrev + 1) % 8];
            else if (r < 15) seg = segTable[$urandom_range(0, 7)];
            else if (r < 17) begin
                seg = 7'($urandom);
                if (decodeSeg(seg) != -2) seg = SEG_ILLEGAL;
            end else if (r == 17) seg = SEG_BLANK;
            else begin
                seg = 7'($urandom);
                valid = 1'b0;
            end
            clr = ($urandom_range(0, 30) == 0);
            applyStimulus(1'b1, seg, valid, clr, "rand");
        end

        for (int i = 0; i < 4; i++) feedDigit(i, "relock3");
        d = 4;
        feedDigit(d, "relock3");
        applyStimulus(1'b0, segTable[5], 1'b1, 1'b0, "midreset");
        checkVal("midreset.LOCKED_const", 32'(LOCKED), 32'd0);
        checkVal("midreset.DIGIT_const", 32'(DIGIT), 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
